// File: rtl/mcse_ahb_bus_bridge.sv
// Boot-control to AHB-Lite bridge: splits one wide payload request into single
// 32-bit NONSEQ transfers and returns one completion pulse with data and error status.
module mcse_ahb_bus_bridge #(
  parameter int unsigned pAHB_ADDR_WIDTH    = 32,
  parameter int unsigned pPAYLOAD_SIZE_BITS = 128,
  parameter int unsigned pTIMEOUT           = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bootControl_bus_go,
  input  logic [pAHB_ADDR_WIDTH-1:0]    bootControl_bus_addr,
  input  logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_write,
  input  logic                          bootControl_bus_RW,
  output logic                          bootControl_bus_done,
  output logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_rdData,
  output logic                          bootControl_bus_err,
  output logic [pAHB_ADDR_WIDTH-1:0]    HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [31:0]                   HWDATA,
  input  logic [31:0]                   HRDATA,
  input  logic                          HREADY,
  input  logic                          HRESP
);

  localparam int unsigned BEATS   = pPAYLOAD_SIZE_BITS / 32;
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ALIGN_W = $clog2(pPAYLOAD_SIZE_BITS / 8);

  localparam logic [pAHB_ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(pAHB_ADDR_WIDTH - ALIGN_W){1'b1}}, {ALIGN_W{1'b0}}};
  localparam logic [pAHB_ADDR_WIDTH-1:0] BEAT_STRIDE = 4;
  localparam logic [BEAT_W-1:0]          LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [7:0]                 TMO_LAST    = 8'(pTIMEOUT - 1);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e                         r_state;
  logic [BEAT_W-1:0]              r_beat;
  logic [7:0]                     r_tmo;
  logic [BEATS-1:0][31:0]         r_payload;
  logic [BEATS-1:0][31:0]         r_buf;
  logic [pPAYLOAD_SIZE_BITS-1:0]  r_rd_data;
  logic                           r_rw;
  logic                           r_done;
  logic                           r_err;
  logic [pAHB_ADDR_WIDTH-1:0]     r_haddr;
  logic [1:0]                     r_htrans;
  logic                           r_hwrite;
  logic [31:0]                    r_hwdata;

  logic [BEATS-1:0][31:0]         w_merged;
  logic                           w_tmo_hit;
  logic                           w_last;

  // Read buffer with the current beat's word replaced by the bus data.
  always_comb begin
    w_merged         = r_buf;
    w_merged[r_beat] = HRDATA;
  end

  // The cycle that would be the pTIMEOUT-th consecutive wait ends the transaction.
  assign w_tmo_hit = !HREADY && (r_tmo == TMO_LAST);
  assign w_last    = (r_beat == LAST_BEAT);

  // Transaction FSM; all bus and completion outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_beat    <= '0;
      r_tmo     <= '0;
      r_payload <= '0;
      r_buf     <= '0;
      r_rd_data <= '0;
      r_rw      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_haddr   <= '0;
      r_htrans  <= TransIdle;
      r_hwrite  <= 1'b0;
      r_hwdata  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bootControl_bus_go) begin
            r_haddr   <= bootControl_bus_addr & ALIGN_MASK;
            r_payload <= bootControl_bus_write;
            r_rw      <= bootControl_bus_RW;
            r_hwrite  <= bootControl_bus_RW;
            r_htrans  <= TransNonseq;
            r_beat    <= '0;
            r_tmo     <= '0;
            r_err     <= 1'b0;
            r_state   <= StAddr;
          end
        end
        StAddr: begin
          if (HREADY) begin
            r_tmo    <= '0;
            r_htrans <= TransIdle;
            r_hwdata <= r_rw ? r_payload[r_beat] : 32'h0;
            r_state  <= StData;
          end else if (w_tmo_hit) begin
            r_err    <= 1'b1;
            r_done   <= 1'b1;
            r_htrans <= TransIdle;
            r_state  <= StDone;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        StData: begin
          if (HREADY) begin
            r_tmo <= '0;
            if (HRESP) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              if (!r_rw) r_buf <= w_merged;
              if (w_last) begin
                // Publish read data with the done pulse; writes leave it alone.
                if (!r_rw) r_rd_data <= w_merged;
                r_done  <= 1'b1;
                r_state <= StDone;
              end else begin
                r_beat   <= r_beat + 1'b1;
                r_haddr  <= r_haddr + BEAT_STRIDE;
                r_htrans <= TransNonseq;
                r_state  <= StAddr;
              end
            end
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        StDone: begin
          r_tmo   <= '0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bootControl_bus_done   = r_done;
  assign bootControl_bus_err    = r_err;
  assign bootControl_bus_rdData = r_rd_data;
  assign HADDR                  = r_haddr;
  assign HTRANS                 = r_htrans;
  assign HWRITE                 = r_hwrite;
  assign HWDATA                 = r_hwdata;
  assign HSIZE                  = 3'b010;
  assign HBURST                 = 3'b000;

endmodule
